// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: receiver state encoding, prefix bytes and timing constants.
package ps2_pkg;

    localparam int unsigned TMR_W  = 17;
    localparam int unsigned BYTE_W = 8;

    localparam logic [TMR_W-1:0]  T_TIMEOUT = 17'd100000;
    localparam logic [TMR_W-1:0]  T100US    = 17'd5000;
    localparam logic [BYTE_W-1:0] PS2_E0    = 8'hE0;
    localparam logic [BYTE_W-1:0] PS2_F0    = 8'hF0;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_DATA,
        ST_PARITY,
        ST_STOP,
        ST_DONE,
        ST_ERR
    } ps2_state_e;

    typedef struct packed {
        logic ext;
        logic brk;
    } ps2_tag_t;

endpackage

// File: rtl/ps2_edge_sync.sv
// Two-flop synchronisers for the PS/2 clock and data lines plus a falling-edge
// detector on the synchronised clock.
module ps2_edge_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic ps2_clk,
    input  logic ps2_dat,
    output logic dat,
    output logic clk_fall_c
);

    logic [1:0] clk_sync;
    logic [1:0] dat_sync;
    logic       clk_prev;

    // Lines idle high, so every flop resets to 1 to avoid a false edge on release.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            clk_sync <= 2'b11;
            dat_sync <= 2'b11;
            clk_prev <= 1'b1;
        end else begin
            clk_sync <= {clk_sync[0], ps2_clk};
            dat_sync <= {dat_sync[0], ps2_dat};
            clk_prev <= clk_sync[1];
        end
    end

    assign dat        = dat_sync[1];
    assign clk_fall_c = clk_prev & ~clk_sync[1];

endmodule

// File: rtl/ps2_read_funcmod.sv
// PS/2 device-to-host frame receiver: assembles scan-code bytes, folds E0/F0
// prefixes into a tag and flags framing, parity and timeout errors.
module ps2_read_funcmod #(
    parameter logic [ps2_pkg::TMR_W-1:0] T_TIMEOUT  = ps2_pkg::T_TIMEOUT,
    parameter logic [3:0]                FRAME_BITS = 4'd11
) (
    input  logic       CLOCK,
    input  logic       RESET,
    input  logic       PS2_CLK,
    input  logic       PS2_DAT,
    input  logic       iEn,
    output logic       oTrig,
    output logic [7:0] oData,
    output logic [1:0] oTag,
    output logic       oErr
);
    import ps2_pkg::*;

    // Index of the last data bit: frame minus start, parity and stop, minus one.
    localparam logic [3:0]       LAST_BIT = FRAME_BITS - 4'd4;
    localparam logic [TMR_W-1:0] TMO_LAST = T_TIMEOUT - TMR_W'(1);

    logic dat;
    logic clk_fall;

    ps2_edge_sync u_sync (
        .clk        (CLOCK),
        .rst_n      (RESET),
        .ps2_clk    (PS2_CLK),
        .ps2_dat    (PS2_DAT),
        .dat        (dat),
        .clk_fall_c (clk_fall)
    );

    ps2_state_e        state, state_nxt;
    logic [BYTE_W-1:0] shreg, shreg_nxt;
    logic [3:0]        bit_cnt, bit_cnt_nxt;
    logic              par_bad, par_bad_nxt;
    ps2_tag_t          flags, flags_nxt;
    logic [TMR_W-1:0]  tmr, tmr_nxt;
    logic              trig_nxt, err_nxt;
    logic [BYTE_W-1:0] data_nxt;
    ps2_tag_t          tag_nxt;

    always_ff @(posedge CLOCK or negedge RESET) begin
        if (!RESET) begin
            state   <= ST_IDLE;
            shreg   <= '0;
            bit_cnt <= '0;
            par_bad <= 1'b0;
            flags   <= '0;
            tmr     <= '0;
            oTrig   <= 1'b0;
            oErr    <= 1'b0;
            oData   <= '0;
            oTag    <= '0;
        end else begin
            state   <= state_nxt;
            shreg   <= shreg_nxt;
            bit_cnt <= bit_cnt_nxt;
            par_bad <= par_bad_nxt;
            flags   <= flags_nxt;
            tmr     <= tmr_nxt;
            oTrig   <= trig_nxt;
            oErr    <= err_nxt;
            oData   <= data_nxt;
            oTag    <= tag_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        shreg_nxt   = shreg;
        bit_cnt_nxt = bit_cnt;
        par_bad_nxt = par_bad;
        flags_nxt   = flags;
        tmr_nxt     = clk_fall ? '0 : tmr + TMR_W'(1);
        trig_nxt    = 1'b0;
        err_nxt     = 1'b0;
        data_nxt    = oData;
        tag_nxt     = oTag;

        case (state)
            ST_IDLE: begin
                tmr_nxt = '0;
                if (!iEn) begin
                    flags_nxt = '0;
                end else if (clk_fall && !dat) begin
                    state_nxt   = ST_DATA;
                    bit_cnt_nxt = '0;
                    par_bad_nxt = 1'b0;
                end
            end
            ST_DATA: begin
                if (clk_fall) begin
                    shreg_nxt = {dat, shreg[BYTE_W-1:1]};
                    if (bit_cnt == LAST_BIT) state_nxt = ST_PARITY;
                    else                     bit_cnt_nxt = bit_cnt + 4'd1;
                end
            end
            ST_PARITY: begin
                if (clk_fall) begin
                    par_bad_nxt = ~(^shreg ^ dat);
                    state_nxt   = ST_STOP;
                end
            end
            ST_STOP: begin
                if (clk_fall) state_nxt = (dat && !par_bad) ? ST_DONE : ST_ERR;
            end
            ST_DONE: begin
                state_nxt = ST_IDLE;
                if (shreg == PS2_E0) begin
                    flags_nxt.ext = 1'b1;
                end else if (shreg == PS2_F0) begin
                    flags_nxt.brk = 1'b1;
                end else begin
                    data_nxt  = shreg;
                    tag_nxt   = flags;
                    trig_nxt  = 1'b1;
                    flags_nxt = '0;
                end
            end
            ST_ERR: begin
                err_nxt   = 1'b1;
                shreg_nxt = '0;
                flags_nxt = '0;
                state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase

        // Mid-frame: losing enable aborts silently, a stalled clock is an error.
        if (state inside {ST_DATA, ST_PARITY, ST_STOP}) begin
            if (!iEn)                             state_nxt = ST_IDLE;
            else if (!clk_fall && tmr == TMO_LAST) state_nxt = ST_ERR;
        end
    end

endmodule

// File: tb/tb_ps2_read_funcmod.sv
// Scoreboard bench for the PS/2 receiver: frames are bit-banged on the pins and
// every oTrig/oErr pulse is matched against the expected-event queue.
module tb_ps2_read_funcmod;

    localparam logic [16:0] TMO  = 17'd2000;
    localparam int          HALF = 20;

    logic       CLOCK   = 1'b0;
    logic       RESET   = 1'b0;
    logic       PS2_CLK = 1'b1;
    logic       PS2_DAT = 1'b1;
    logic       iEn     = 1'b0;
    logic       oTrig;
    logic       oErr;
    logic [7:0] oData;
    logic [1:0] oTag;

    ps2_read_funcmod #(
        .T_TIMEOUT  (TMO),
        .FRAME_BITS (4'd11)
    ) dut (
        .CLOCK   (CLOCK),
        .RESET   (RESET),
        .PS2_CLK (PS2_CLK),
        .PS2_DAT (PS2_DAT),
        .iEn     (iEn),
        .oTrig   (oTrig),
        .oData   (oData),
        .oTag    (oTag),
        .oErr    (oErr)
    );

    always #10 CLOCK = ~CLOCK;

    typedef struct {
        bit         is_err;
        logic [7:0] data;
        logic [1:0] tag;
        bit         chk_lat;
    } exp_t;

    exp_t        sb[$];
    exp_t        e_mon;
    int          n_checks = 0;
    int          n_pass   = 0;
    int unsigned cyc      = 0;
    int unsigned stop_cyc = 0;

    always @(posedge CLOCK) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    endtask

    task automatic push_trig(input logic [7:0] d, input logic [1:0] t);
        sb.push_back('{is_err: 1'b0, data: d, tag: t, chk_lat: 1'b1});
    endtask

    task automatic push_err(input bit chk_lat);
        sb.push_back('{is_err: 1'b1, data: 8'h00, tag: 2'b00, chk_lat: chk_lat});
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge CLOCK);
    endtask

    // Device changes data mid-high, then drops the clock; the host samples on the fall.
    task automatic ps2_bit(input logic b, input bit is_stop);
        @(negedge CLOCK);
        PS2_DAT = b;
        idle(HALF / 2);
        PS2_CLK = 1'b0;
        if (is_stop) stop_cyc = cyc;
        idle(HALF);
        PS2_CLK = 1'b1;
        idle(HALF / 2);
    endtask

    task automatic send_frame(input logic [7:0] d, input bit bad_par, input int nbits);
        logic [10:0] f;
        f = {1'b1, (~(^d)) ^ bad_par, d, 1'b0};
        for (int i = 0; i < nbits; i++) ps2_bit(f[i], i == 10);
        PS2_DAT = 1'b1;
    endtask

    // Output monitor: every pulse must match the head of the scoreboard.
    always @(negedge CLOCK) begin
        if (RESET && (oTrig || oErr)) begin
            check("trig_err_exclusive", 32'(oTrig & oErr), 32'd0);
            if (sb.size() == 0) begin
                check("spurious_pulse", {30'd0, oTrig, oErr}, 32'd0);
            end else begin
                e_mon = sb.pop_front();
                check("pulse_kind", 32'(oErr), 32'(e_mon.is_err));
                if (!e_mon.is_err) begin
                    check("data", 32'(oData), 32'(e_mon.data));
                    check("tag", 32'(oTag), 32'(e_mon.tag));
                end
                if (e_mon.chk_lat) check("latency", cyc - stop_cyc, 32'd4);
            end
        end
    end

    initial begin
        #4_000_000;
        $display("FAIL watchdog: simulation did not finish, got %0d expected <= 200000 cycles", cyc);
        $fatal(1);
    end

    initial begin
        idle(3);
        check("rst_trig", 32'(oTrig), 32'd0);
        check("rst_err", 32'(oErr), 32'd0);
        check("rst_data", 32'(oData), 32'd0);
        check("rst_tag", 32'(oTag), 32'd0);
        RESET = 1'b1;
        iEn   = 1'b1;
        idle(10);

        push_trig(8'h1C, 2'b00);
        send_frame(8'h1C, 1'b0, 11);
        idle(30);

        send_frame(8'hE0, 1'b0, 11);
        send_frame(8'hF0, 1'b0, 11);
        push_trig(8'h75, 2'b11);
        send_frame(8'h75, 1'b0, 11);
        idle(30);

        send_frame(8'hE0, 1'b0, 11);
        push_trig(8'h1C, 2'b10);
        send_frame(8'h1C, 1'b0, 11);
        idle(30);

        push_err(1'b1);
        send_frame(8'h1C, 1'b1, 11);
        idle(30);
        push_trig(8'h32, 2'b00);
        send_frame(8'h32, 1'b0, 11);
        idle(30);

        push_trig(8'h12, 2'b00);
        send_frame(8'h12, 1'b0, 11);
        push_trig(8'h34, 2'b00);
        send_frame(8'h34, 1'b0, 11);
        idle(30);

        // Break prefix, then a frame that stalls after six data bits.
        send_frame(8'hF0, 1'b0, 11);
        push_err(1'b0);
        send_frame(8'hA5, 1'b0, 7);
        idle(int'(TMO) + 200);
        push_trig(8'h1C, 2'b00);
        send_frame(8'h1C, 1'b0, 11);
        idle(30);

        // Reset in the middle of data bit 4 after a break prefix.
        send_frame(8'hF0, 1'b0, 11);
        send_frame(8'h55, 1'b0, 5);
        RESET = 1'b0;
        idle(3);
        check("midrst_trig", 32'(oTrig), 32'd0);
        check("midrst_err", 32'(oErr), 32'd0);
        check("midrst_data", 32'(oData), 32'd0);
        check("midrst_tag", 32'(oTag), 32'd0);
        RESET = 1'b1;
        idle(30);
        push_trig(8'h29, 2'b00);
        send_frame(8'h29, 1'b0, 11);
        idle(30);

        iEn = 1'b0;
        send_frame(8'h1C, 1'b0, 11);
        idle(30);
        check("hold_data", 32'(oData), 32'h29);
        check("hold_tag", 32'(oTag), 32'd0);

        // Enable dropped mid-frame aborts quietly.
        iEn = 1'b1;
        idle(10);
        send_frame(8'h4A, 1'b0, 4);
        iEn = 1'b0;
        idle(20);
        iEn = 1'b1;
        idle(20);
        push_trig(8'h4A, 2'b00);
        send_frame(8'h4A, 1'b0, 11);

        for (int i = 0; i < 200 && sb.size() != 0; i++) @(negedge CLOCK);
        check("scoreboard_drained", 32'(sb.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
